minterm_sweep_checker: RTL and testbench

Sequential stimulus-and-capture stage wrapped around the 3-variable Boolean function block. On each start request it drives {A,B,C} through minterms 0..7, waits a programmable settle time at each minterm, and samples F to build an 8-bit truth table. It then compares the captured table with an expected minterm mask and reports pass/fail and a per-minterm mismatch vector. This replaces open-loop testbench sweeps with a synthesizable self-check that can sit on-chip beside the function block.

---
 rtl/minterm_sweep_pkg.sv | 19 +
 rtl/sweep_settle_timer.sv | 33 +++
 rtl/minterm_sweep_checker.sv | 155 +++++++++++++++
 tb/tb_minterm_sweep_checker.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/minterm_sweep_pkg.sv
// Shared types and widths for the minterm sweep checker.
//   state_t      : sweep FSM states
//   NUM_MINTERMS : minterms of a 3-input function
//   IDX_W        : minterm index width
//   CNT_W        : settle counter width
package minterm_sweep_pkg;

   localparam int unsigned NUM_MINTERMS = 8;
   localparam int unsigned IDX_W        = 3;
   localparam int unsigned CNT_W        = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_SAMPLE,
      ST_DONE
   } state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Settle-time counter for the minterm sweep.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : synchronous clear (wins over i_en)
//   i_en       : count enable
//   o_tc_c     : combinational terminal count, high when count == SETTLE-1
module sweep_settle_timer
   import minterm_sweep_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc_c
);

   logic [CNT_W-1:0] r_cnt;

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tc_c = (r_cnt == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/minterm_sweep_checker.sv
// Drives {A,B,C} through minterms 0..7, samples F after SETTLE cycles at each,
// and compares the captured truth table against a latched expectation.
//   clk, rst_n : clock, async active-low reset
//   start      : sweep request, honoured only when idle
//   exp_tt     : expected truth table, latched on start accept
//   F          : function output under test
//   A, B, C    : minterm drive, A is the MSB
//   busy       : sweep in progress
//   done       : one-cycle result-valid pulse
//   tt         : captured truth table
//   pass       : tt matched the latched expectation
//   mismatch   : per-minterm difference against the latched expectation
module minterm_sweep_checker
   import minterm_sweep_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [NUM_MINTERMS-1:0] exp_tt,
   input  logic                    F,
   output logic                    A,
   output logic                    B,
   output logic                    C,
   output logic                    busy,
   output logic                    done,
   output logic [NUM_MINTERMS-1:0] tt,
   output logic                    pass,
   output logic [NUM_MINTERMS-1:0] mismatch
);

   state_t                  r_state;
   state_t                  w_next;
   logic                    w_clr;
   logic                    w_en;
   logic                    w_tc;
   logic                    w_last;
   logic [IDX_W-1:0]        r_idx;
   logic [NUM_MINTERMS-1:0] r_exp;
   logic [NUM_MINTERMS-1:0] r_shadow;
   logic [NUM_MINTERMS-1:0] w_shadow_next;
   logic [IDX_W-1:0]        r_abc;
   logic                    r_busy;
   logic                    r_done;
   logic [NUM_MINTERMS-1:0] r_tt;
   logic                    r_pass;
   logic [NUM_MINTERMS-1:0] r_mism;

   sweep_settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_clr),
      .i_en   (w_en),
      .o_tc_c (w_tc)
   );

   assign w_last = (r_idx == IDX_W'(NUM_MINTERMS - 1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and timer control
   always_comb begin
      w_next = r_state;
      w_clr  = 1'b0;
      w_en   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_clr = 1'b1;
            if (start) begin
               w_next = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            w_en = 1'b1;
            if (w_tc) begin
               w_next = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (w_last) begin
               w_next = ST_DONE;
            end else begin
               w_clr  = 1'b1;
               w_next = ST_SETTLE;
            end
         end
         ST_DONE: begin
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   // Shadow table with the current sample merged in, so the last minterm is
   // included when results are loaded on the same edge.
   always_comb begin
      w_shadow_next        = r_shadow;
      w_shadow_next[r_idx] = F;
   end

   // Index, shadow table, latched expectation and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx    <= '0;
         r_exp    <= '0;
         r_shadow <= '0;
         r_abc    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_tt     <= '0;
         r_pass   <= 1'b0;
         r_mism   <= '0;
      end else begin
         if ((r_state == ST_IDLE) && start) begin
            r_exp <= exp_tt;
            r_idx <= '0;
         end
         if (r_state == ST_SAMPLE) begin
            r_shadow <= w_shadow_next;
            if (w_last) begin
               r_tt   <= w_shadow_next;
               r_pass <= (w_shadow_next == r_exp);
               r_mism <= w_shadow_next ^ r_exp;
            end else begin
               r_idx <= r_idx + IDX_W'(1);
            end
         end
         r_busy <= (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
         r_abc  <= ((r_state == ST_SETTLE) || (r_state == ST_SAMPLE)) ? r_idx : '0;
         r_done <= (r_state == ST_DONE);
      end
   end

   assign A        = r_abc[2];
   assign B        = r_abc[1];
   assign C        = r_abc[0];
   assign busy     = r_busy;
   assign done     = r_done;
   assign tt       = r_tt;
   assign pass     = r_pass;
   assign mismatch = r_mism;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: one instance with SETTLE=1 driven by a
// combinational majority function, one with SETTLE=3 driven by an XOR3
// function with two cycles of latency.
module tb_minterm_sweep_checker;

   typedef struct {
      logic [7:0] tt;
      logic       pass;
      logic [7:0] mism;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start1, start3;
   logic [7:0] exp1, exp3;
   logic       f1, f3;
   logic       a1, b1, c1, busy1, done1, pass1;
   logic       a3, b3, c3, busy3, done3, pass3;
   logic [7:0] tt1, mism1, tt3, mism3;

   logic [7:0] tbl1 = 8'hE8;
   logic [7:0] tbl3 = 8'h96;
   logic       d1 = 1'b0;
   logic       d2 = 1'b0;

   logic       sel3;
   logic [2:0] s_abc;
   logic       s_busy, s_done, s_pass;
   logic [7:0] s_tt, s_mism;

   res_t sb[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   minterm_sweep_checker #(.SETTLE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .exp_tt(exp1), .F(f1),
      .A(a1), .B(b1), .C(c1), .busy(busy1), .done(done1),
      .tt(tt1), .pass(pass1), .mismatch(mism1)
   );

   minterm_sweep_checker #(.SETTLE(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .exp_tt(exp3), .F(f3),
      .A(a3), .B(b3), .C(c3), .busy(busy3), .done(done3),
      .tt(tt3), .pass(pass3), .mismatch(mism3)
   );

   assign f1 = tbl1[{a1, b1, c1}];

   always @(posedge clk) begin
      d1 <= tbl3[{a3, b3, c3}];
      d2 <= d1;
   end
   assign f3 = d2;

   always_comb begin
      if (sel3) begin
         s_abc  = {a3, b3, c3};
         s_busy = busy3;
         s_done = done3;
         s_tt   = tt3;
         s_pass = pass3;
         s_mism = mism3;
      end else begin
         s_abc  = {a1, b1, c1};
         s_busy = busy1;
         s_done = done1;
         s_tt   = tt1;
         s_pass = pass1;
         s_mism = mism1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] t, input logic p, input logic [7:0] m);
      res_t r;
      r.tt   = t;
      r.pass = p;
      r.mism = m;
      sb.push_back(r);
   endtask

   // Request a sweep; the edge inside this task is the accept edge.
   task automatic launch(input logic s3, input logic [7:0] e, input logic hold);
      sel3 = s3;
      if (s3) begin
         exp3   = e;
         start3 = 1'b1;
      end else begin
         exp1   = e;
         start1 = 1'b1;
      end
      tick();
      if (!hold) begin
         start1 = 1'b0;
         start3 = 1'b0;
      end
   endtask

   // Follow a sweep from the cycle after accept to done, then score it.
   task automatic wait_done(input string tag, input int p, input logic poke_start,
                            input logic poke_exp);
      int   got       = 0;
      int   abc_err   = 0;
      logic pulsed    = 1'b0;
      logic clr_next  = 1'b0;
      res_t r;
      r.tt   = 8'h00;
      r.pass = 1'b0;
      r.mism = 8'hFF;
      for (int j = 1; j <= 200; j++) begin
         if (clr_next) begin
            start1   = 1'b0;
            clr_next = 1'b0;
         end
         tick();
         if (j <= 8 * p) begin
            if ((s_abc !== 3'((j - 1) / p)) || (s_busy !== 1'b1)) abc_err++;
         end
         if (poke_exp && (j == 5)) exp1 = 8'hE8;
         if (poke_start && !pulsed && (s_abc == 3'd3)) begin
            start1   = 1'b1;
            pulsed   = 1'b1;
            clr_next = 1'b1;
         end
         if (s_done === 1'b1) begin
            got = j;
            break;
         end
      end
      if (clr_next) start1 = 1'b0;
      check({tag, "_latency"}, got, 8 * p + 1);
      check({tag, "_abc_seq"}, abc_err, 0);
      if (sb.size() > 0) r = sb.pop_front();
      check({tag, "_tt"}, s_tt, r.tt);
      check({tag, "_pass"}, s_pass, r.pass);
      check({tag, "_mismatch"}, s_mism, r.mism);
      tick();
      check({tag, "_done_fall"}, s_done, 0);
      check({tag, "_busy_fall"}, s_busy, 0);
   endtask

   initial begin
      logic       seen;
      logic       found;
      logic [7:0] acc;

      rst_n  = 1'b0;
      start1 = 1'b0;
      start3 = 1'b0;
      exp1   = 8'h00;
      exp3   = 8'h00;
      sel3   = 1'b0;

      // Reset and idle
      tick();
      tick();
      check("rst_outs1", {a1, b1, c1, busy1, done1, tt1, pass1, mism1}, 0);
      check("rst_outs3", {a3, b3, c3, busy3, done3, tt3, pass3, mism3}, 0);
      rst_n = 1'b1;
      acc = 8'h00;
      for (int i = 0; i < 20; i++) begin
         tick();
         acc = acc | {a1, b1, c1, busy1, done1, pass1, a3, done3} | tt1 | mism1 | tt3 | mism3;
      end
      check("idle_quiet", acc, 0);

      // Majority function, matching expectation
      push_exp(8'hE8, 1'b1, 8'h00);
      launch(1'b0, 8'hE8, 1'b0);
      wait_done("maj_good", 2, 1'b0, 1'b0);

      // Wrong expectation, changed after accept, plus ignored start at idx 3
      push_exp(8'hE8, 1'b0, 8'h01);
      launch(1'b0, 8'hE9, 1'b0);
      wait_done("maj_wrong", 2, 1'b1, 1'b1);

      // Start held high: second sweep accepted in the IDLE cycle after DONE
      push_exp(8'hE8, 1'b1, 8'h00);
      push_exp(8'hE8, 1'b1, 8'h00);
      launch(1'b0, 8'hE8, 1'b1);
      wait_done("hold_first", 2, 1'b0, 1'b0);
      start1 = 1'b0;
      wait_done("hold_second", 2, 1'b0, 1'b0);

      // Reset mid-sweep at minterm 4
      launch(1'b0, 8'hE8, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (s_abc == 3'd4) begin
            found = 1'b1;
            break;
         end
      end
      check("abort_reach_idx4", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_zeros", {a1, b1, c1, busy1, done1, tt1, pass1, mism1}, 0);
      tick();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen = seen | done1 | busy1;
      end
      check("abort_no_done", seen, 0);
      push_exp(8'hE8, 1'b1, 8'h00);
      launch(1'b0, 8'hE8, 1'b0);
      wait_done("restart", 2, 1'b0, 1'b0);

      // XOR3 with two cycles of latency, SETTLE=3
      push_exp(8'h96, 1'b1, 8'h00);
      launch(1'b1, 8'h96, 1'b0);
      wait_done("xor3_slow", 4, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
